ps2_key_tx_queue: RTL and testbench

//  Consumes the PS/2 receiver's {previous byte, latest byte} scan-code word and its flag.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_key_tx_queue_if.sv | 8 +
 rtl/ps2_key_tx_queue_fifo.sv | 38 +++
 rtl/ps2_key_tx_queue.sv | 68 ++++++
 tb/tb_ps2_key_tx_queue.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 set-2 scan-code constants and the scan-code to ASCII map
package ps2_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0, SC_EXT = 8'hE0, SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59;
  localparam logic [7:0] ASCII_CR = 8'h0D, ASCII_BS = 8'h08, ASCII_SP = 8'h20;
  function automatic logic [7:0] sc2ascii(input logic [7:0] sc, input logic shift);
    logic [7:0] c;
    case (sc)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
      8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
      8'h3E: c = "8";  8'h46: c = "9";
      8'h29: c = ASCII_SP;
      8'h5A: c = ASCII_CR;
      8'h66: c = ASCII_BS;
      default: c = 8'h00;
    endcase
    // only letters have an upper-case form
    return (shift && c >= "a" && c <= "z") ? c - 8'h20 : c;
  endfunction
endpackage

// File: rtl/ps2_key_tx_queue_if.sv
// ps2_key_tx_queue_if: valid/ready character stream toward the UART transmitter
interface ps2_key_tx_queue_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_key_tx_queue_fifo.sv
// sync_fifo: first-word-fall-through FIFO with explicit occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign rd = pop & ~empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign wr = push & (~full | rd);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/ps2_key_tx_queue.sv
// ps2_key_tx_queue: filters PS/2 make/break codes, tracks Shift, maps to ASCII
// and queues the characters for the UART transmitter.
module ps2_key_tx_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       keycode,
  input  logic              key_flag,
  ps2_key_tx_queue_if.master tx,
  output logic [ADDR_W:0]   count,
  output logic              shift_on,
  output logic              overflow
);
  logic [7:0] hi, lo, d_code, l_code, ascii;
  logic flag_q, ev, is_pfx, is_brk, is_make;
  logic lshift, rshift, d_vld, l_vld, l_shift;
  logic push, pop, full, empty;
  assign hi = keycode[15:8];
  assign lo = keycode[7:0];
  assign ev = key_flag & ~flag_q;
  assign is_pfx = lo == SC_BREAK || lo == SC_EXT;
  assign is_brk = ev & ~is_pfx & hi == SC_BREAK;
  assign is_make = ev & ~is_pfx & hi != SC_BREAK & hi != SC_EXT;
  assign shift_on = lshift | rshift;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_q <= 1'b0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      d_vld <= 1'b0;
      d_code <= '0;
      l_vld <= 1'b0;
      l_code <= '0;
      l_shift <= 1'b0;
      overflow <= 1'b0;
    end else begin
      flag_q <= key_flag;
      if (is_brk && lo == SC_LSHIFT) lshift <= 1'b0;
      else if (is_make && lo == SC_LSHIFT) lshift <= 1'b1;
      if (is_brk && lo == SC_RSHIFT) rshift <= 1'b0;
      else if (is_make && lo == SC_RSHIFT) rshift <= 1'b1;
      d_vld <= is_make & lo != SC_LSHIFT & lo != SC_RSHIFT;
      d_code <= lo;
      l_vld <= d_vld;
      l_code <= d_code;
      l_shift <= shift_on;
      overflow <= overflow | (push & full & ~pop);
    end
  assign ascii = sc2ascii(l_code, l_shift);
  assign push = l_vld & |ascii;
  assign pop = tx.tx_valid & tx.tx_ready;
  assign tx.tx_valid = ~empty;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(ascii),
    .dout(tx.tx_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_ps2_key_tx_queue.sv
// tb_ps2_key_tx_queue: randomized and directed checks against a queue-based key model
module tb_ps2_key_tx_queue;
  logic clk = 1'b0, rst_n = 1'b0, key_flag = 1'b0;
  logic [15:0] keycode = '0;
  logic [4:0] count;
  logic shift_on, overflow;
  ps2_key_tx_queue_if tx_if();
  ps2_key_tx_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode), .key_flag(key_flag),
    .tx(tx_if), .count(count), .shift_on(shift_on), .overflow(overflow)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, rdy_pct = 0;
  bit rnd_rdy = 0;
  logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] kmap(logic [7:0] sc, bit sh);
    for (int i = 0; i < 26; i++) if (let_sc[i] == sc) return 8'((sh ? 65 : 97) + i);
    for (int i = 0; i < 10; i++) if (dig_sc[i] == sc) return 8'(48 + i);
    if (sc == 8'h29) return 8'h20;
    if (sc == 8'h5A) return 8'h0D;
    if (sc == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct {int due; logic [7:0] code;} pend_t;
  pend_t pq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit m_l = 0, m_r = 0, m_ovf = 0, m_flag = 0;
  int cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete(); mq.delete();
      m_l = 0; m_r = 0; m_ovf = 0; m_flag = 0;
    end else begin
      bit pop, psh;
      logic [7:0] ch, hi, lo;
      pop = mq.size() > 0 && tx_if.tx_ready;
      psh = 0; ch = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        ch = kmap(pq[0].code, m_l | m_r);
        psh = ch != 0;
        void'(pq.pop_front());
      end
      hi = keycode[15:8]; lo = keycode[7:0];
      if (key_flag && !m_flag) begin
        if (lo == 8'hF0 || lo == 8'hE0) ;
        else if (hi == 8'hF0) begin
          if (lo == 8'h12) m_l = 0;
          if (lo == 8'h59) m_r = 0;
        end else if (hi == 8'hE0) ;
        else if (lo == 8'h12) m_l = 1;
        else if (lo == 8'h59) m_r = 1;
        else pq.push_back('{cyc + 2, lo});
      end
      m_flag = key_flag;
      if (pop) void'(mq.pop_front());
      if (psh) begin
        if (mq.size() < 16) mq.push_back(ch);
        else m_ovf = 1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("tx_valid", tx_if.tx_valid, mq.size() > 0);
    if (mq.size() > 0) chk("tx_data", tx_if.tx_data, mq[0]);
    chk("count", count, mq.size());
    chk("shift_on", shift_on, m_l | m_r);
    chk("overflow", overflow, m_ovf);
  end

  always @(posedge clk)
    if (rst_n && tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) tx_if.tx_ready = $urandom_range(0, 99) < rdy_pct;
  endtask

  task automatic key(logic [15:0] kc, int len = 1, int gap = 4);
    keycode = kc; key_flag = 1;
    repeat (len) tick();
    key_flag = 0;
    repeat (gap) tick();
  endtask

  task automatic drain();
    rnd_rdy = 0; tx_if.tx_ready = 1;
    for (int i = 0; i < 400 && (mq.size() > 0 || pq.size() > 0); i++) tick();
    repeat (2) tick();
    chk("drained count", count, 0);
  endtask

  task automatic rst_pulse();
    rst_n = 0; tick(); rst_n = 1; tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tx_if.tx_ready = 0;
    repeat (3) tick();
    chk("reset count", count, 0);
    chk("reset tx_valid", tx_if.tx_valid, 0);
    rst_n = 1; tick();
    // 1: plain make, latency and pop
    tx_if.tx_ready = 1; got.delete();
    keycode = 16'h001C; key_flag = 1; tick();
    key_flag = 0; tick();
    chk("t1 valid N+2", tx_if.tx_valid, 0);
    tick();
    chk("t1 valid N+3", tx_if.tx_valid, 1);
    chk("t1 data", tx_if.tx_data, 8'h61);
    tick();
    chk("t1 count N+4", count, 0);
    drain();
    chk("t1 chars", got.size(), 1);
    // 2: shift
    got.delete();
    key(16'h0012);
    chk("t2 shift held", shift_on, 1);
    key(16'h121C);
    key(16'h1CF0);
    key(16'hF012);
    chk("t2 shift released", shift_on, 0);
    key(16'h121C);
    drain();
    chk("t2 chars", got.size(), 2);
    if (got.size() == 2) begin
      chk("t2 upper", got[0], 8'h41);
      chk("t2 lower", got[1], 8'h61);
    end
    // 3: break and prefix filtering
    got.delete();
    key(16'h00F0); key(16'hF01C); key(16'h00E0); key(16'hE075);
    chk("t3 count", count, 0);
    drain();
    chk("t3 chars", got.size(), 0);
    // 4: backpressure and overflow
    tx_if.tx_ready = 0;
    for (int i = 0; i < 17; i++) key({8'h00, let_sc[i]});
    chk("t4 count", count, 16);
    chk("t4 overflow", overflow, 1);
    got.delete(); drain();
    chk("t4 chars", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t4 order", got[i], 8'(97 + i));
    // 5: full with simultaneous push/pop
    rst_pulse();
    tx_if.tx_ready = 0;
    for (int i = 0; i < 16; i++) key({8'h00, let_sc[i]});
    chk("t5 full", count, 16);
    keycode = 16'h001A; key_flag = 1; tick();
    key_flag = 0; tick();
    tx_if.tx_ready = 1; tick();
    tx_if.tx_ready = 0;
    chk("t5 count", count, 16);
    chk("t5 overflow", overflow, 0);
    got.delete(); drain();
    chk("t5 chars", got.size(), 16);
    if (got.size() == 16) begin
      chk("t5 first", got[0], 8'h62);
      chk("t5 last", got[15], 8'h7A);
    end
    // 6: reset mid-stream
    tx_if.tx_ready = 0;
    key(16'h0059);
    for (int i = 0; i < 5; i++) key({8'h00, let_sc[i]});
    chk("t6 queued", count, 5);
    chk("t6 shift", shift_on, 1);
    rst_n = 0; #4;
    chk("t6 async count", count, 0);
    chk("t6 async valid", tx_if.tx_valid, 0);
    chk("t6 async shift", shift_on, 0);
    tick(); rst_n = 1; tick();
    got.delete();
    key(16'h0016);
    drain();
    chk("t6 chars", got.size(), 1);
    if (got.size() == 1) chk("t6 digit", got[0], 8'h31);
    // random traffic: balanced, then heavy backpressure to hit overflow
    for (int ph = 0; ph < 2; ph++) begin
      rdy_pct = ph ? 5 : 50; rnd_rdy = 1;
      for (int e = 0; e < 150; e++) begin
        logic [7:0] l, p;
        int k;
        k = $urandom_range(0, 9);
        l = let_sc[$urandom_range(0, 25)];
        p = let_sc[$urandom_range(0, 25)];
        case (k)
          0, 1, 2, 3: keycode = {p, l};
          4: keycode = {8'h00, dig_sc[$urandom_range(0, 9)]};
          5: keycode = {8'h00, ($urandom_range(0, 1) ? 8'h12 : 8'h59)};
          6: keycode = {8'hF0, ($urandom_range(0, 2) == 0 ? l : ($urandom_range(0, 1) ? 8'h12 : 8'h59))};
          7: keycode = {l, ($urandom_range(0, 1) ? 8'hF0 : 8'hE0)};
          8: keycode = {8'hE0, l};
          default: keycode = {8'h00, 8'(($urandom_range(0, 3) == 0) ? 8'h0E :
                              ($urandom_range(0, 1) ? 8'h29 : ($urandom_range(0, 1) ? 8'h5A : 8'h66)))};
        endcase
        key(keycode, $urandom_range(1, 3), $urandom_range(3, 5));
      end
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
